// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl
//   BCD stopwatch (mm:ss.cc, rolls over 59:59.99 -> 00:00.00) with start/stop,
//   clear, a circular lap buffer and lap recall. Feeds a 4-digit BCD value bus
//   to the FND display path.
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   btn_pedge  one-cycle pulses: [0] start/stop, [1] lap, [2] clear, [3] recall
//   disp_mode  0: ss.cc on value, 1: mm.ss on value
//   value      registered BCD digits {d3,d2,d1,d0}
//   running    1 while counting
//   lap_view   1 while value shows a stored lap
//   lap_sel    1-based index of the lap shown (0 in live view)
//   lap_count  stored laps, saturates at LAP_DEPTH
//   wrap       one-cycle pulse on 59:59.99 -> 00:00.00
module stopwatch_lap_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 4,
  localparam int unsigned LW       = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    btn_pedge,
  input  logic          disp_mode,
  output logic [15:0]   value,
  output logic          running,
  output logic          lap_view,
  output logic [LW-1:0] lap_sel,
  output logic [LW-1:0] lap_count,
  output logic          wrap
);

  localparam int unsigned CLK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PTR_W   = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  typedef enum logic {ST_STOP, ST_RUN} run_state_e;
  typedef enum logic {V_LIVE, V_LAP} view_e;

  // Time layout: {m10, m1, s10, s1, c10, c1}, one BCD digit per nibble.
  logic [23:0]      time_q, time_d;
  logic [PW-1:0]    presc_q, presc_d;
  run_state_e       state_q, state_d;
  view_e            view_q, view_d;
  logic [LW-1:0]    sel_q, sel_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [23:0]      lap_buf_q [LAP_DEPTH];
  logic [23:0]      lap_buf_d [LAP_DEPTH];
  logic [15:0]      value_q, value_d;
  logic             wrap_q, wrap_d;

  logic             btn_start, btn_lap, btn_clear, btn_recall;
  logic             tick, full, carry;
  logic [PTR_W-1:0] rd_idx;

  assign btn_start  = btn_pedge[0];
  assign btn_lap    = btn_pedge[1];
  assign btn_clear  = btn_pedge[2];
  assign btn_recall = btn_pedge[3];

  assign full = (cnt_q == LW'(LAP_DEPTH));
  assign tick = (state_q == ST_RUN) && (presc_q == PW'(CLK_DIV - 1));

  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  always_comb begin
    state_d   = state_q;
    view_d    = view_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    time_d    = time_q;
    presc_d   = presc_q;
    wrap_d    = 1'b0;
    carry     = tick;
    lap_buf_d = lap_buf_q;

    // Prescaler holds while stopped so a partial tick survives a pause.
    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] == digit_max(i)) begin
          time_d[4*i +: 4] = '0;
        end else begin
          time_d[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    wrap_d = carry;

    // Priority: clear > start/stop > lap > recall; lower pulses are dropped.
    if (btn_clear) begin
      time_d  = '0;
      presc_d = '0;
      wrap_d  = 1'b0;
      state_d = ST_STOP;
      view_d  = V_LIVE;
      sel_d   = '0;
      cnt_d   = '0;
      ptr_d   = '0;
      for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
        lap_buf_d[i] = '0;
      end
    end else if (btn_start) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end else if (btn_lap) begin
      if (state_q == ST_RUN) begin
        // Captures the time shown before this cycle's tick.
        lap_buf_d[ptr_q] = time_q;
        ptr_d = (ptr_q == PTR_W'(LAP_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        if (!full) begin
          cnt_d = cnt_q + LW'(1);
        end else begin
          // Overwrite moves the oldest entry; a held index would now be stale.
          view_d = V_LIVE;
          sel_d  = '0;
        end
      end
    end else if (btn_recall && cnt_q != '0) begin
      if (view_q == V_LIVE) begin
        view_d = V_LAP;
        sel_d  = LW'(1);
      end else if (sel_q == cnt_q) begin
        view_d = V_LIVE;
        sel_d  = '0;
      end else begin
        sel_d = sel_q + LW'(1);
      end
    end
  end

  // Oldest entry sits at index 0 until the buffer fills, then at the write pointer.
  always_comb begin
    int unsigned base_i;
    int unsigned sum_i;
    base_i = full ? int'(ptr_q) : 0;
    sum_i  = base_i + ((sel_q == '0) ? 0 : int'(sel_q) - 1);
    if (sum_i >= LAP_DEPTH) begin
      sum_i = sum_i - LAP_DEPTH;
    end
    rd_idx = PTR_W'(sum_i);
  end

  always_comb begin
    logic [23:0] src;
    src     = (view_q == V_LAP) ? lap_buf_q[rd_idx] : time_q;
    value_d = disp_mode ? src[23:8] : src[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
      view_q  <= V_LIVE;
      sel_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      time_q  <= '0;
      presc_q <= '0;
      value_q <= '0;
      wrap_q  <= 1'b0;
      for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
        lap_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      view_q    <= view_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      time_q    <= time_d;
      presc_q   <= presc_d;
      value_q   <= value_d;
      wrap_q    <= wrap_d;
      lap_buf_q <= lap_buf_d;
    end
  end

  assign value     = value_q;
  assign running   = (state_q == ST_RUN);
  assign lap_view  = (view_q == V_LAP);
  assign lap_sel   = sel_q;
  assign lap_count = cnt_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Scoreboard bench for stopwatch_lap_ctrl: the reference model keeps time as
// total centiseconds and the lap buffer as an oldest-first queue.
module tb_stopwatch_lap_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned LW      = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    btn_pedge = '0;
  logic          disp_mode = 1'b0;
  logic [15:0]   value;
  logic          running, lap_view, wrap;
  logic [LW-1:0] lap_sel, lap_count;

  stopwatch_lap_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .btn_pedge(btn_pedge), .disp_mode(disp_mode),
    .value(value), .running(running), .lap_view(lap_view), .lap_sel(lap_sel),
    .lap_count(lap_count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   value;
    logic          running;
    logic          lap_view;
    logic [LW-1:0] lap_sel;
    logic [LW-1:0] lap_count;
    logic          wrap;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_t;          // elapsed centiseconds, 0..359999
  int   m_runedges;   // clock edges spent running since clear/reset
  bit   m_run;
  int   m_laps[$];    // oldest first
  int   m_sel;        // 0 = live view

  function automatic logic [15:0] disp(input int t, input logic mode);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    if (mode) return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    return {4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic void model_reset();
    m_t = 0; m_runedges = 0; m_run = 0; m_laps.delete(); m_sel = 0;
  endfunction

  function automatic void model_step(input logic [3:0] b, input logic mode, input logic rstn);
    obs_t e;
    int   src;
    bit   tck, wr;
    e = '0;
    if (!rstn) begin
      model_reset();
      exp_q.push_back(e);
      return;
    end
    src = (m_sel != 0) ? m_laps[m_sel-1] : m_t;
    e.value = disp(src, mode);
    wr  = 0;
    tck = 0;
    if (b[2]) begin
      model_reset();
    end else begin
      if (m_run) begin
        m_runedges++;
        tck = ((m_runedges % CLK_DIV) == 0);
      end
      if (b[0]) begin
        m_run = !m_run;
      end else if (b[1]) begin
        if (m_run) begin
          m_laps.push_back(m_t);
          if (m_laps.size() > DEPTH) begin
            void'(m_laps.pop_front());
            m_sel = 0;
          end
        end
      end else if (b[3] && m_laps.size() > 0) begin
        m_sel = (m_sel == m_laps.size()) ? 0 : m_sel + 1;
      end
      if (tck) begin
        m_t++;
        if (m_t == 360000) begin
          m_t = 0;
          wr  = 1;
        end
      end
    end
    e.running   = m_run;
    e.lap_view  = (m_sel != 0);
    e.lap_sel   = LW'(m_sel);
    e.lap_count = LW'(m_laps.size());
    e.wrap      = wr;
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input logic [3:0] b, input logic mode, input logic rstn);
    @(negedge clk);
    btn_pedge = b;
    disp_mode = mode;
    reset_n   = rstn;
    @(posedge clk);
    model_step(b, mode, rstn);
  endtask

  task automatic idle(input int n, input logic mode);
    for (int i = 0; i < n; i++) cycle(4'b0000, mode, 1'b1);
  endtask

  function automatic obs_t sample();
    obs_t a;
    a = {value, running, lap_view, lap_sel, lap_count, wrap};
    return a;
  endfunction

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_out @%0t: got value=%h run=%b view=%b sel=%0d cnt=%0d wrap=%b, want value=%h run=%b view=%b sel=%0d cnt=%0d wrap=%b",
                   $time, a.value, a.running, a.lap_view, a.lap_sel, a.lap_count, a.wrap,
                   e.value, e.running, e.lap_view, e.lap_sel, e.lap_count, e.wrap);
        end
      end
    end
  end

  initial begin
    logic [3:0] b;
    logic       mode;
    obs_t       a;
    model_reset();

    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);
    idle(5, 1'b0);

    // 1000 running cycles -> 01.00, then freeze after stop
    cycle(4'b0001, 1'b0, 1'b1);
    idle(1000, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(20, 1'b0);
    idle(3, 1'b1);

    // Pause partway through a tick and resume
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(15, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(30, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(20, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);

    // Rollover from 59:59.99
    cycle(4'b0100, 1'b0, 1'b1);
    #2;
    force dut.time_q = 24'h595999;
    m_t = 359999;
    cycle(4'b0000, 1'b0, 1'b1);
    #2;
    release dut.time_q;
    idle(2, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(12, 1'b0);
    idle(3, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);

    // Laps: recall on empty buffer, five laps into four slots, recall walk
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      idle(37, 1'b0);
      cycle(4'b0010, 1'b0, 1'b1);
    end
    idle(3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1000, 1'b0, 1'b1);
      idle(4, 1'b1);
    end
    cycle(4'b1000, 1'b0, 1'b1);
    idle(3, 1'b0);
    cycle(4'b0010, 1'b0, 1'b1);
    idle(3, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Clear + start + lap together
    cycle(4'b0111, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Async reset while running, between clock edges
    cycle(4'b0001, 1'b0, 1'b1);
    idle(50, 1'b0);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    a = sample();
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h, want 0", a);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    idle(20, 1'b0);

    // Random traffic
    mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      b = '0;
      if ($urandom_range(59) == 0)  b[0] = 1'b1;
      if ($urandom_range(7) == 0)   b[1] = 1'b1;
      if ($urandom_range(249) == 0) b[2] = 1'b1;
      if ($urandom_range(6) == 0)   b[3] = 1'b1;
      if ($urandom_range(31) == 0)  mode = ~mode;
      cycle(b, mode, 1'b1);
    end

    #20;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
